// File: rtl/clock_digit_formatter.sv
// Timekeeping core feeding the 7-segment decoder: keeps hh:mm:ss, handles set mode
// with field blink, and registers 4-bit digit codes in 12h or 24h format.
module clock_digit_formatter #(
    parameter int SEC_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_12h,
    input  logic       set_en,
    input  logic [1:0] set_field,
    input  logic       inc,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] ampm,
    output logic       sec_strobe
);

    localparam int PW = (SEC_DIV > 2) ? $clog2(SEC_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(SEC_DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(SEC_DIV / 2);

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;
    localparam logic [3:0] CODE_AM    = 4'd12;
    localparam logic [3:0] CODE_PM    = 4'd13;

    logic [PW-1:0] r_presc;
    logic [4:0]    r_hour;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic          r_set_en_d;
    logic          r_clr;
    logic          r_sec_strobe;
    logic [3:0]    r_hr_tens, r_hr_ones, r_min_tens, r_min_ones;
    logic [3:0]    r_sec_tens, r_sec_ones, r_ampm;

    logic          w_terminal;
    logic          w_blink_on;
    logic          w_advance;
    logic          w_inc;
    logic [4:0]    w_disp_hour;
    logic          w_pm;
    logic [7:0]    w_hr_code, w_min_code, w_sec_code;
    logic [3:0]    w_hr_tens, w_hr_ones, w_min_tens, w_min_ones;
    logic [3:0]    w_sec_tens, w_sec_ones, w_ampm;

    // Tens/ones split by descending compare-and-subtract; inputs never exceed 59.
    function automatic logic [7:0] bin2code(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        t = 4'd0;
        r = v;
        if (r >= 6'd50) begin
            t = 4'd5; r = r - 6'd50;
        end else if (r >= 6'd40) begin
            t = 4'd4; r = r - 6'd40;
        end else if (r >= 6'd30) begin
            t = 4'd3; r = r - 6'd30;
        end else if (r >= 6'd20) begin
            t = 4'd2; r = r - 6'd20;
        end else if (r >= 6'd10) begin
            t = 4'd1; r = r - 6'd10;
        end
        return {t, 4'(r)};
    endfunction

    // A pending clear from a set-mode exit suppresses any terminal in the same cycle.
    assign w_terminal = (r_presc == TERM) && !r_clr;
    assign w_blink_on = (r_presc < HALF);
    assign w_advance  = w_terminal && !set_en;
    assign w_inc      = set_en && inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_set_en_d   <= 1'b0;
            r_clr        <= 1'b0;
            r_sec_strobe <= 1'b0;
        end else begin
            r_set_en_d   <= set_en;
            r_clr        <= r_set_en_d && !set_en;
            r_sec_strobe <= w_terminal;
            if (r_clr || (r_presc == TERM)) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hour <= '0;
            r_min  <= '0;
            r_sec  <= '0;
        end else if (w_advance) begin
            if (r_sec == 6'd59) begin
                r_sec <= '0;
                if (r_min == 6'd59) begin
                    r_min  <= '0;
                    r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                end else begin
                    r_min <= r_min + 6'd1;
                end
            end else begin
                r_sec <= r_sec + 6'd1;
            end
        end else if (w_inc) begin
            case (set_field)
                2'd0:    r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                2'd1:    r_min  <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                2'd2:    r_sec  <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_disp_hour = r_hour;
        w_pm        = (r_hour >= 5'd12);
        if (mode_12h) begin
            if (r_hour == 5'd0) begin
                w_disp_hour = 5'd12;
            end else if (r_hour > 5'd12) begin
                w_disp_hour = r_hour - 5'd12;
            end
        end
        w_hr_code  = bin2code({1'b0, w_disp_hour});
        w_min_code = bin2code(r_min);
        w_sec_code = bin2code(r_sec);

        w_hr_tens  = w_hr_code[7:4];
        w_hr_ones  = w_hr_code[3:0];
        w_min_tens = w_min_code[7:4];
        w_min_ones = w_min_code[3:0];
        w_sec_tens = w_sec_code[7:4];
        w_sec_ones = w_sec_code[3:0];
        w_ampm     = CODE_BLANK;

        if (mode_12h) begin
            w_ampm = w_pm ? CODE_PM : CODE_AM;
            if (w_disp_hour < 5'd10) begin
                w_hr_tens = CODE_BLANK;
            end
        end

        // Blink blanks only the selected field's digits; ampm stays visible.
        if (set_en && !w_blink_on) begin
            case (set_field)
                2'd0: begin
                    w_hr_tens = CODE_BLANK;
                    w_hr_ones = CODE_BLANK;
                end
                2'd1: begin
                    w_min_tens = CODE_BLANK;
                    w_min_ones = CODE_BLANK;
                end
                2'd2: begin
                    w_sec_tens = CODE_BLANK;
                    w_sec_ones = CODE_BLANK;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hr_tens  <= CODE_DASH;
            r_hr_ones  <= CODE_DASH;
            r_min_tens <= CODE_DASH;
            r_min_ones <= CODE_DASH;
            r_sec_tens <= CODE_DASH;
            r_sec_ones <= CODE_DASH;
            r_ampm     <= CODE_BLANK;
        end else begin
            r_hr_tens  <= w_hr_tens;
            r_hr_ones  <= w_hr_ones;
            r_min_tens <= w_min_tens;
            r_min_ones <= w_min_ones;
            r_sec_tens <= w_sec_tens;
            r_sec_ones <= w_sec_ones;
            r_ampm     <= w_ampm;
        end
    end

    assign hr_tens    = r_hr_tens;
    assign hr_ones    = r_hr_ones;
    assign min_tens   = r_min_tens;
    assign min_ones   = r_min_ones;
    assign sec_tens   = r_sec_tens;
    assign sec_ones   = r_sec_ones;
    assign ampm       = r_ampm;
    assign sec_strobe = r_sec_strobe;

endmodule

// File: tb/tb_clock_digit_formatter.sv
// Bench for clock_digit_formatter with a 4-cycle second: expected display words are
// queued when stimulus is applied and popped when the DUT output is sampled.
module tb_clock_digit_formatter;

    localparam int SEC_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       mode_12h;
    logic       set_en;
    logic [1:0] set_field;
    logic       inc;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, ampm;
    logic       sec_strobe;

    logic [27:0] obs;
    logic [27:0] exp_q[$];
    logic [27:0] exp_w;
    int vectors = 0;
    int miscompares = 0;

    assign obs = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, ampm};

    clock_digit_formatter #(.SEC_DIV(SEC_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .mode_12h(mode_12h), .set_en(set_en),
        .set_field(set_field), .inc(inc),
        .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .ampm(ampm), .sec_strobe(sec_strobe)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference display word; blank selects a field to show as 10,10 (-1 none).
    function automatic logic [27:0] disp(int h, int m, int s, bit m12, int blank);
        int dh;
        logic [3:0] ht, ho, mt, mo, st, so, ap;
        dh = h;
        ap = 4'd10;
        if (m12) begin
            if (h == 0) dh = 12;
            else if (h > 12) dh = h - 12;
            ap = (h >= 12) ? 4'd13 : 4'd12;
        end
        ht = 4'(dh / 10); ho = 4'(dh % 10);
        if (m12 && dh < 10) ht = 4'd10;
        mt = 4'(m / 10); mo = 4'(m % 10);
        st = 4'(s / 10); so = 4'(s % 10);
        if (blank == 0) begin ht = 4'd10; ho = 4'd10; end
        if (blank == 1) begin mt = 4'd10; mo = 4'd10; end
        if (blank == 2) begin st = 4'd10; so = 4'd10; end
        return {ht, ho, mt, mo, st, so, ap};
    endfunction

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; mode_12h = 1'b0; set_en = 1'b0; set_field = 2'd3; inc = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (sec_strobe === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Loads hours/minutes from 00:00 by holding inc, clears seconds; leaves set mode on, field 3.
    task automatic set_time(input int h, input int m);
        set_en = 1'b1;
        set_field = 2'd0; inc = (h > 0); tick(h);
        set_field = 2'd1; inc = (m > 0); tick(m);
        set_field = 2'd2; inc = 1'b1; tick(1);
        inc = 1'b0; set_field = 2'd3; tick(2);
    endtask

    task automatic test_reset();
        int strobes;
        rst_n = 1'b0; mode_12h = 1'b0; set_en = 1'b0; set_field = 2'd3; inc = 1'b0;
        #12;
        vectors++;
        if (obs !== {{6{4'd11}}, 4'd10} || sec_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got %h strobe %b, want %h strobe 0", obs, sec_strobe,
                     {{6{4'd11}}, 4'd10});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(disp(0, 0, 0, 0, -1));
        exp_q.push_back(disp(0, 0, 0, 0, -1));
        exp_q.push_back(disp(0, 0, 1, 0, -1));
        tick(1);
        exp_w = exp_q.pop_front();
        vectors++;
        if (obs !== exp_w) begin
            miscompares++;
            $display("FAIL first_edge: got %h want %h", obs, exp_w);
        end
        tick(3);
        exp_w = exp_q.pop_front();
        vectors++;
        if (obs !== exp_w || sec_strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL strobe_edge: got %h strobe %b want %h strobe 1", obs, sec_strobe, exp_w);
        end
        tick(1);
        exp_w = exp_q.pop_front();
        vectors++;
        if (obs !== exp_w || sec_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL first_second: got %h strobe %b want %h strobe 0", obs, sec_strobe, exp_w);
        end
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (sec_strobe === 1'b1) strobes++;
        end
        vectors++;
        if (strobes != 3) begin
            miscompares++;
            $display("FAIL strobe_rate: got %0d strobes want 3", strobes);
        end
    endtask

    task automatic test_rollover();
        bit ok;
        int lost;
        apply_reset();
        set_time(23, 59);
        wait_strobe(ok);
        set_en = 1'b0;
        lost = ok ? 0 : 1;
        for (int i = 0; i < 58; i++) begin
            wait_strobe(ok);
            if (!ok) lost++;
        end
        vectors++;
        if (lost != 0) begin
            miscompares++;
            $display("FAIL rollover_strobes: got %0d missing strobes want 0", lost);
        end
        exp_q.push_back(disp(23, 59, 58, 0, -1));
        exp_q.push_back(disp(23, 59, 58, 0, -1));
        exp_q.push_back(disp(23, 59, 59, 0, -1));
        exp_q.push_back(disp(23, 59, 59, 0, -1));
        exp_q.push_back(disp(0, 0, 0, 0, -1));
        for (int k = 0; k < 5; k++) begin
            if (k == 1 || k == 3) begin
                wait_strobe(ok);
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL rollover_wait: got timeout want strobe");
                end
            end else begin
                tick(1);
            end
            exp_w = exp_q.pop_front();
            vectors++;
            if (obs !== exp_w) begin
                miscompares++;
                $display("FAIL rollover_%0d: got %h want %h", k, obs, exp_w);
            end
        end
    endtask

    task automatic test_format();
        int hrs[6] = '{0, 9, 12, 13, 23, 7};
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            mode_12h = (i < 5);
            set_time(hrs[i], (i == 5) ? 5 : 0);
            exp_q.push_back(disp(hrs[i], (i == 5) ? 5 : 0, 0, (i < 5), -1));
            exp_w = exp_q.pop_front();
            vectors++;
            if (obs !== exp_w) begin
                miscompares++;
                $display("FAIL format_h%0d: got %h want %h", hrs[i], obs, exp_w);
            end
        end
    endtask

    task automatic test_set_minutes_blink();
        bit ok;
        apply_reset();
        set_time(5, 59);
        set_field = 2'd1; inc = 1'b1;
        tick(1);
        inc = 1'b0;
        tick(2);
        wait_strobe(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL blink_wait: got timeout want strobe");
        end
        for (int k = 0; k < 12; k++)
            exp_q.push_back(disp(5, 0, 0, 0, (k % 4 == 0 || k % 4 == 3) ? 1 : -1));
        for (int k = 0; k < 12; k++) begin
            exp_w = exp_q.pop_front();
            vectors++;
            if (obs !== exp_w || sec_strobe !== (k % 4 == 0)) begin
                miscompares++;
                $display("FAIL blink_%0d: got %h strobe %b want %h strobe %b", k, obs, sec_strobe,
                         exp_w, (k % 4 == 0));
            end
            tick(1);
        end
        set_en = 1'b0; set_field = 2'd3;
    endtask

    task automatic test_set_seconds();
        bit ok;
        int lost;
        apply_reset();
        lost = 0;
        for (int i = 0; i < 37; i++) begin
            wait_strobe(ok);
            if (!ok) lost++;
        end
        set_en = 1'b1; set_field = 2'd3;
        tick(2);
        exp_q.push_back(disp(0, 0, 37, 0, -1));
        exp_w = exp_q.pop_front();
        vectors++;
        if (obs !== exp_w || lost != 0) begin
            miscompares++;
            $display("FAIL sec_37: got %h lost %0d want %h lost 0", obs, lost, exp_w);
        end
        set_field = 2'd2; inc = 1'b1;
        tick(1);
        inc = 1'b0; set_field = 2'd3;
        tick(1);
        exp_q.push_back(disp(0, 0, 0, 0, -1));
        exp_w = exp_q.pop_front();
        vectors++;
        if (obs !== exp_w) begin
            miscompares++;
            $display("FAIL sec_clear: got %h want %h", obs, exp_w);
        end
        inc = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(disp(0, 0, 0, 0, -1));
        for (int k = 0; k < 6; k++) begin
            tick(1);
            exp_w = exp_q.pop_front();
            vectors++;
            if (obs !== exp_w) begin
                miscompares++;
                $display("FAIL field3_inc_%0d: got %h want %h", k, obs, exp_w);
            end
        end
        inc = 1'b0; set_en = 1'b0;
    endtask

    task automatic test_reset_mid_set();
        apply_reset();
        set_time(3, 4);
        set_field = 2'd0;
        tick(1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== {{6{4'd11}}, 4'd10} || sec_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %h strobe %b want %h strobe 0", obs, sec_strobe,
                     {{6{4'd11}}, 4'd10});
        end
        set_en = 1'b0; set_field = 2'd3;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        exp_q.push_back(disp(0, 0, 0, 0, -1));
        exp_w = exp_q.pop_front();
        vectors++;
        if (obs !== exp_w) begin
            miscompares++;
            $display("FAIL after_reset: got %h want %h", obs, exp_w);
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_format();
        test_set_minutes_blink();
        test_set_seconds();
        test_reset_mid_set();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
